// File: rtl/imem_loader_if.sv
// Host/serial side and instruction-memory write side of the loader, bundled as one port.
// master = host/serial driver, slave = imem_loader.
interface imem_loader_if #(
    parameter int ADDR_DATA_WIDTH = 32
);
    logic                       start;
    logic [9:0]                 word_count;
    logic                       byte_valid;
    logic [7:0]                 byte_data;
    logic                       byte_ready;
    logic                       imem_wr_en;
    logic [ADDR_DATA_WIDTH-1:0] imem_wr_addr;
    logic [ADDR_DATA_WIDTH-1:0] imem_wr_data;
    logic                       core_reset;
    logic                       busy;
    logic                       done;
    logic                       error;

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
               core_reset, busy, done, error
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
               core_reset, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Serial-byte to instruction-memory loader: four little-endian bytes per word, one WRITE cycle per word.
// Stalls indefinitely on byte_valid low; byte_ready is high for the whole of RECV and nowhere else.
module imem_loader #(
    parameter int ADDR_DATA_WIDTH = 32,
    parameter int IMEM_DEPTH      = 512
) (
    input  logic          clk1,
    input  logic          reset1,
    imem_loader_if.slave  bus
);
    localparam int         AW      = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [10:0] DEPTH_W = 11'(IMEM_DEPTH);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

    state_t                     state_q, state_d;
    logic [9:0]                 count_q, count_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [1:0]                 idx_q, idx_d;
    logic [23:0]                asm_q, asm_d;
    logic [ADDR_DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                       error_q, error_d;

    logic count_ok;
    logic last_word;

    assign count_ok  = (bus.word_count != 10'd0) && ({1'b0, bus.word_count} <= DEPTH_W);
    assign last_word = (32'(addr_q) == (32'(count_q) - 32'd1));

    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            state_q   <= IDLE;
            count_q   <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            asm_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        error_d   = error_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (count_ok) begin
                        count_d = bus.word_count;
                        addr_d  = '0;
                        idx_d   = '0;
                        error_d = 1'b0;
                        state_d = RECV;
                    end else begin
                        error_d = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            RECV: begin
                if (bus.byte_valid) begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: asm_d[7:0]   = bus.byte_data;
                        2'd1: asm_d[15:8]  = bus.byte_data;
                        2'd2: asm_d[23:16] = bus.byte_data;
                        default: begin
                            // Write port is loaded here so it is valid throughout WRITE and holds afterwards.
                            wr_addr_d = ADDR_DATA_WIDTH'(addr_q);
                            wr_data_d = ADDR_DATA_WIDTH'({bus.byte_data, asm_q});
                            state_d   = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    idx_d   = '0;
                    state_d = RECV;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.byte_ready   = (state_q == RECV);
    assign bus.imem_wr_en   = (state_q == WRITE);
    assign bus.imem_wr_addr = wr_addr_q;
    assign bus.imem_wr_data = wr_data_q;
    assign bus.busy         = (state_q == RECV) || (state_q == WRITE) || (state_q == DONE);
    assign bus.done         = (state_q == DONE);
    assign bus.error        = error_q;
    assign bus.core_reset   = reset1 | bus.busy;
endmodule

// File: tb/tb_imem_loader.sv
// Drives byte streams into imem_loader and compares every memory write against words
// rebuilt from the byte list with plain little-endian arithmetic.
module tb_imem_loader;
    localparam int W = 32;
    localparam int D = 512;

    logic clk1 = 1'b0;
    logic reset1;
    always #5 clk1 = ~clk1;

    imem_loader_if #(.ADDR_DATA_WIDTH(W)) bus ();
    imem_loader #(.ADDR_DATA_WIDTH(W), .IMEM_DEPTH(D)) dut (
        .clk1   (clk1),
        .reset1 (reset1),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          done_cnt = 0;
    wr_t         obs_q[$];
    logic [7:0]  bq[$];

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (bus.imem_wr_en === 1'b1) obs_q.push_back('{bus.imem_wr_addr, bus.imem_wr_data, cyc});
        if (bus.done === 1'b1) done_cnt++;
    end

    function automatic logic [31:0] model_word(input int i);
        return 32'(bq[4*i]) + 32'(bq[4*i+1]) * 256 + 32'(bq[4*i+2]) * 65536 + 32'(bq[4*i+3]) * 16777216;
    endfunction

    task automatic fill_random(input int nbytes);
        bq.delete();
        for (int i = 0; i < nbytes; i++) bq.push_back(8'($urandom));
    endtask

    task automatic start_session(input int wc);
        bus.start      = 1'b1;
        bus.word_count = 10'(wc);
        @(negedge clk1);
        bus.start      = 1'b0;
        bus.word_count = 10'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit rdy_in_gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            if (rdy_in_gap) begin
                total++;
                if (bus.byte_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_byte_ready got=%b want=1", bus.byte_ready);
                end
            end
            @(negedge clk1);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk1);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL byte_ready_timeout got=%b want=1", bus.byte_ready);
        end
        @(negedge clk1);
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        int n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk1);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=%b want=1", bus.done);
        end
        dcyc = cyc;
    endtask

    task automatic test_reset();
        reset1 = 1'b1;
        #1;
        total += 8;
        if (bus.byte_ready !== 1'b0)   begin bad++; $display("FAIL rst_byte_ready got=%b want=0", bus.byte_ready); end
        if (bus.imem_wr_en !== 1'b0)   begin bad++; $display("FAIL rst_wr_en got=%b want=0", bus.imem_wr_en); end
        if (bus.imem_wr_addr !== 32'd0) begin bad++; $display("FAIL rst_wr_addr got=%h want=0", bus.imem_wr_addr); end
        if (bus.imem_wr_data !== 32'd0) begin bad++; $display("FAIL rst_wr_data got=%h want=0", bus.imem_wr_data); end
        if (bus.busy !== 1'b0)         begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        if (bus.done !== 1'b0)         begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
        if (bus.error !== 1'b0)        begin bad++; $display("FAIL rst_error got=%b want=0", bus.error); end
        if (bus.core_reset !== 1'b1)   begin bad++; $display("FAIL rst_core_reset got=%b want=1", bus.core_reset); end
        repeat (3) @(negedge clk1);
        reset1 = 1'b0;
        @(negedge clk1);
        total++;
        if (bus.core_reset !== 1'b0) begin bad++; $display("FAIL idle_core_reset got=%b want=0", bus.core_reset); end
    endtask

    task automatic test_back_to_back();
        int base = obs_q.size();
        int dbase = done_cnt;
        int dcyc;
        bq = '{8'hB3, 8'h82, 8'h41, 8'h00, 8'h33, 8'h83, 8'h41, 8'h40};
        start_session(2);
        total++;
        if (bus.core_reset !== 1'b1) begin bad++; $display("FAIL b2b_core_reset_busy got=%b want=1", bus.core_reset); end
        for (int k = 0; k < 8; k++) send_byte(bq[k], 0, 1'b0);
        wait_done(dcyc);
        total++;
        if (obs_q.size() - base != 2) begin bad++; $display("FAIL b2b_nwrites got=%0d want=2", obs_q.size() - base); end
        for (int i = 0; i < 2 && base + i < obs_q.size(); i++) begin
            total++;
            if (obs_q[base+i].addr !== 32'(i) || obs_q[base+i].data !== model_word(i)) begin
                bad++;
                $display("FAIL b2b_write%0d got=%h:%h want=%h:%h", i, obs_q[base+i].addr, obs_q[base+i].data, i, model_word(i));
            end
        end
        total++;
        if (obs_q.size() > base && dcyc !== obs_q[obs_q.size()-1].cyc + 1) begin
            bad++;
            $display("FAIL b2b_done_timing got=%0d want=%0d", dcyc, obs_q[obs_q.size()-1].cyc + 1);
        end
        @(negedge clk1);
        total += 3;
        if (bus.busy !== 1'b0)       begin bad++; $display("FAIL b2b_busy_after got=%b want=0", bus.busy); end
        if (bus.core_reset !== 1'b0) begin bad++; $display("FAIL b2b_core_reset_after got=%b want=0", bus.core_reset); end
        if (done_cnt - dbase != 1)   begin bad++; $display("FAIL b2b_done_count got=%0d want=1", done_cnt - dbase); end
    endtask

    task automatic test_stall();
        int base = obs_q.size();
        int dcyc;
        bq = '{8'hB3, 8'h82, 8'h41, 8'h00, 8'h33, 8'h83, 8'h41, 8'h40};
        start_session(2);
        for (int k = 0; k < 8; k++) send_byte(bq[k], 3, (k % 4) != 0);
        wait_done(dcyc);
        repeat (4) @(negedge clk1);
        total++;
        if (obs_q.size() - base != 2) begin bad++; $display("FAIL stall_nwrites got=%0d want=2", obs_q.size() - base); end
        for (int i = 0; i < 2 && base + i < obs_q.size(); i++) begin
            total++;
            if (obs_q[base+i].addr !== 32'(i) || obs_q[base+i].data !== model_word(i)) begin
                bad++;
                $display("FAIL stall_write%0d got=%h:%h want=%h:%h", i, obs_q[base+i].addr, obs_q[base+i].data, i, model_word(i));
            end
        end
    endtask

    task automatic test_error();
        int base = obs_q.size();
        int dcyc;
        start_session(0);
        total += 2;
        if (bus.error !== 1'b1) begin bad++; $display("FAIL err0_error got=%b want=1", bus.error); end
        if (bus.busy !== 1'b0)  begin bad++; $display("FAIL err0_busy got=%b want=0", bus.busy); end
        repeat (3) @(negedge clk1);
        start_session(513);
        repeat (4) @(negedge clk1);
        total += 3;
        if (bus.error !== 1'b1)        begin bad++; $display("FAIL err513_error got=%b want=1", bus.error); end
        if (bus.busy !== 1'b0)         begin bad++; $display("FAIL err513_busy got=%b want=0", bus.busy); end
        if (obs_q.size() != base)      begin bad++; $display("FAIL err_writes got=%0d want=0", obs_q.size() - base); end
        fill_random(4);
        start_session(1);
        total++;
        if (bus.error !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", bus.error); end
        for (int k = 0; k < 4; k++) send_byte(bq[k], 0, 1'b0);
        wait_done(dcyc);
        @(negedge clk1);
        total++;
        if (obs_q.size() - base != 1 || obs_q[obs_q.size()-1].data !== model_word(0)) begin
            bad++;
            $display("FAIL err_recover_write got=%0d want=1", obs_q.size() - base);
        end
    endtask

    task automatic test_reset_abort();
        int base = obs_q.size();
        int dcyc;
        fill_random(8);
        start_session(2);
        for (int k = 0; k < 6; k++) send_byte(bq[k], 0, 1'b0);
        reset1 = 1'b1;
        #1;
        total += 7;
        if (bus.byte_ready !== 1'b0)    begin bad++; $display("FAIL abort_byte_ready got=%b want=0", bus.byte_ready); end
        if (bus.imem_wr_en !== 1'b0)    begin bad++; $display("FAIL abort_wr_en got=%b want=0", bus.imem_wr_en); end
        if (bus.imem_wr_addr !== 32'd0) begin bad++; $display("FAIL abort_wr_addr got=%h want=0", bus.imem_wr_addr); end
        if (bus.imem_wr_data !== 32'd0) begin bad++; $display("FAIL abort_wr_data got=%h want=0", bus.imem_wr_data); end
        if (bus.busy !== 1'b0)          begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
        if (bus.done !== 1'b0)          begin bad++; $display("FAIL abort_done got=%b want=0", bus.done); end
        if (bus.core_reset !== 1'b1)    begin bad++; $display("FAIL abort_core_reset got=%b want=1", bus.core_reset); end
        @(negedge clk1);
        reset1 = 1'b0;
        @(negedge clk1);
        total++;
        if (obs_q.size() - base != 1 || obs_q[obs_q.size()-1].addr !== 32'd0 || obs_q[obs_q.size()-1].data !== model_word(0)) begin
            bad++;
            $display("FAIL abort_partial_writes got=%0d want=1", obs_q.size() - base);
        end
        base = obs_q.size();
        fill_random(4);
        start_session(1);
        for (int k = 0; k < 4; k++) send_byte(bq[k], 0, 1'b0);
        wait_done(dcyc);
        @(negedge clk1);
        total++;
        if (obs_q.size() - base != 1 || obs_q[obs_q.size()-1].addr !== 32'd0 || obs_q[obs_q.size()-1].data !== model_word(0)) begin
            bad++;
            $display("FAIL abort_restart_addr0 got=%0d writes want=1", obs_q.size() - base);
        end
    endtask

    task automatic test_restart_ignored();
        int base = obs_q.size();
        int dbase = done_cnt;
        int dcyc;
        fill_random(8);
        start_session(2);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin bus.start = 1'b1; bus.word_count = 10'd5; end
            if (k == 6) bus.start = 1'b0;
            send_byte(bq[k], $urandom_range(0, 1), 1'b0);
        end
        wait_done(dcyc);
        repeat (10) @(negedge clk1);
        total += 3;
        if (obs_q.size() - base != 2) begin bad++; $display("FAIL restart_nwrites got=%0d want=2", obs_q.size() - base); end
        if (done_cnt - dbase != 1)    begin bad++; $display("FAIL restart_done_count got=%0d want=1", done_cnt - dbase); end
        if (bus.busy !== 1'b0)        begin bad++; $display("FAIL restart_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_random();
        for (int s = 0; s < 6; s++) begin
            int base = obs_q.size();
            int wc = $urandom_range(1, 12);
            int dcyc;
            fill_random(4 * wc);
            start_session(wc);
            for (int k = 0; k < 4 * wc; k++) send_byte(bq[k], $urandom_range(0, 2), (k % 4) != 0);
            wait_done(dcyc);
            @(negedge clk1);
            total++;
            if (obs_q.size() - base != wc) begin bad++; $display("FAIL rand%0d_nwrites got=%0d want=%0d", s, obs_q.size() - base, wc); end
            for (int i = 0; i < wc && base + i < obs_q.size(); i++) begin
                total++;
                if (obs_q[base+i].addr !== 32'(i) || obs_q[base+i].data !== model_word(i)) begin
                    bad++;
                    $display("FAIL rand%0d_write%0d got=%h:%h want=%h:%h", s, i, obs_q[base+i].addr, obs_q[base+i].data, i, model_word(i));
                end
            end
        end
    endtask

    task automatic test_full_depth();
        int base = obs_q.size();
        int dcyc;
        bq.delete();
        for (int i = 0; i < 4 * D; i++) bq.push_back(8'(i));
        start_session(D);
        for (int k = 0; k < 4 * D; k++) send_byte(bq[k], 0, 1'b0);
        wait_done(dcyc);
        repeat (4) @(negedge clk1);
        total += 2;
        if (obs_q.size() - base != D) begin bad++; $display("FAIL full_nwrites got=%0d want=%0d", obs_q.size() - base, D); end
        if (obs_q[obs_q.size()-1].addr !== 32'(D - 1)) begin
            bad++;
            $display("FAIL full_last_addr got=%0d want=%0d", obs_q[obs_q.size()-1].addr, D - 1);
        end
        for (int i = 0; i < D && base + i < obs_q.size(); i++) begin
            total++;
            if (obs_q[base+i].addr !== 32'(i) || obs_q[base+i].data !== model_word(i)) begin
                bad++;
                $display("FAIL full_write%0d got=%h:%h want=%h:%h", i, obs_q[base+i].addr, obs_q[base+i].data, i, model_word(i));
            end
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.word_count = 10'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        reset1         = 1'b1;
        test_reset();
        test_back_to_back();
        test_stall();
        test_error();
        test_reset_abort();
        test_restart_ignored();
        test_random();
        test_full_depth();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
